// File: rtl/trdb_pkg.sv
// rtl/trdb_pkg.sv - shared types and helpers for the trace resync controller
package trdb_pkg;

    typedef enum logic [1:0] {
        SYNC_START   = 2'd0,
        SYNC_FORCE   = 2'd1,
        SYNC_TIMEOUT = 2'd2,
        SYNC_NONE    = 2'd3
    } sync_cause_e;

    typedef enum logic [1:0] {
        ST_OFF   = 2'd0,
        ST_IDLE  = 2'd1,
        ST_REQ   = 2'd2,
        ST_CLEAR = 2'd3
    } resync_state_e;

    // Bit positions inside the pending-flag vector
    localparam int unsigned FLAG_START   = 0;
    localparam int unsigned FLAG_FORCE   = 1;
    localparam int unsigned FLAG_TIMEOUT = 2;

    // Highest-priority pending cause: START > FORCE > TIMEOUT
    function automatic sync_cause_e pick_cause(input logic [2:0] flags);
        if (flags[FLAG_START]) begin
            return SYNC_START;
        end else if (flags[FLAG_FORCE]) begin
            return SYNC_FORCE;
        end else if (flags[FLAG_TIMEOUT]) begin
            return SYNC_TIMEOUT;
        end
        return SYNC_NONE;
    endfunction

    // Pending-flag bit that a given cause serves
    function automatic logic [2:0] cause_mask(input sync_cause_e cause);
        case (cause)
            SYNC_START:   return 3'b001;
            SYNC_FORCE:   return 3'b010;
            SYNC_TIMEOUT: return 3'b100;
            default:      return 3'b000;
        endcase
    endfunction

endpackage

// File: rtl/trdb_resync_ctrl.sv
// rtl/trdb_resync_ctrl.sv - arbitrates sync packet requests and clears the resync counter
module trdb_resync_ctrl
    import trdb_pkg::*;
#(
    parameter int unsigned MERGE_CNT_W = 8
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  logic                   trace_enabled_i,
    input  logic                   trace_start_i,
    input  logic                   force_sync_i,
    input  logic                   gt_resync_max_i,
    input  logic                   et_resync_max_i,
    input  logic                   sync_ready_i,
    output logic                   sync_valid_o,
    output logic [1:0]             sync_cause_o,
    output logic                   resync_rst_o,
    output logic                   resync_imminent_o,
    output logic [MERGE_CNT_W-1:0] merged_cnt_o
);

    resync_state_e          state_q;
    sync_cause_e            cause_q;
    logic [2:0]             flags_q;
    logic                   gt_q;
    logic                   valid_q;
    logic                   rst_pulse_q;
    logic [MERGE_CNT_W-1:0] merged_q;

    logic       gt_rise;
    logic [2:0] new_events;
    logic [2:0] eff_flags;
    logic       xfer;
    logic       merge_hit;

    // Fold this cycle's events into the pending set so they are acted on without delay
    always_comb begin
        gt_rise    = gt_resync_max_i & ~gt_q;
        new_events = {gt_rise, force_sync_i, trace_start_i};
        eff_flags  = flags_q | new_events;
        xfer       = valid_q & sync_ready_i;
        merge_hit  = |(eff_flags & ~cause_mask(cause_q));
    end

    // Request FSM with registered outputs; loss of enable aborts from any active state
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= ST_OFF;
            cause_q     <= SYNC_NONE;
            flags_q     <= 3'b000;
            gt_q        <= 1'b0;
            valid_q     <= 1'b0;
            rst_pulse_q <= 1'b0;
            merged_q    <= '0;
        end else begin
            gt_q        <= gt_resync_max_i;
            rst_pulse_q <= 1'b0;
            if (state_q == ST_OFF) begin
                // Only the start pulse survives while tracing is off
                flags_q[FLAG_START] <= flags_q[FLAG_START] | trace_start_i;
                if (trace_enabled_i) begin
                    state_q <= ST_IDLE;
                end
            end else if (!trace_enabled_i) begin
                state_q     <= ST_OFF;
                flags_q     <= 3'b000;
                valid_q     <= 1'b0;
                cause_q     <= SYNC_NONE;
                rst_pulse_q <= 1'b1;
            end else if (state_q == ST_REQ) begin
                if (xfer) begin
                    state_q     <= ST_CLEAR;
                    flags_q     <= 3'b000;
                    valid_q     <= 1'b0;
                    cause_q     <= SYNC_NONE;
                    rst_pulse_q <= 1'b1;
                    if (merge_hit && (merged_q != {MERGE_CNT_W{1'b1}})) begin
                        merged_q <= merged_q + MERGE_CNT_W'(1);
                    end
                end else begin
                    flags_q <= eff_flags;
                end
            end else begin
                // IDLE and CLEAR both launch a new request when anything is pending
                flags_q <= eff_flags;
                if (|eff_flags) begin
                    state_q <= ST_REQ;
                    valid_q <= 1'b1;
                    cause_q <= pick_cause(eff_flags);
                end else begin
                    state_q <= ST_IDLE;
                end
            end
        end
    end

    assign sync_valid_o      = valid_q;
    assign sync_cause_o      = cause_q;
    assign resync_rst_o      = rst_pulse_q;
    assign merged_cnt_o      = merged_q;
    assign resync_imminent_o = et_resync_max_i & trace_enabled_i & (state_q == ST_IDLE);

endmodule

// File: tb/tb_trdb_resync_ctrl.sv
// tb/tb_trdb_resync_ctrl.sv - self-checking bench for trdb_resync_ctrl
module tb_trdb_resync_ctrl;

    localparam int MW     = 2;
    localparam int CNTMAX = (1 << MW) - 1;

    logic          clk;
    logic          rst_n;
    logic          en;
    logic          start;
    logic          force_s;
    logic          gt;
    logic          et;
    logic          ready;
    logic          valid;
    logic [1:0]    cause;
    logic          rst_pulse;
    logic          imminent;
    logic [MW-1:0] merged;

    trdb_resync_ctrl #(.MERGE_CNT_W(MW)) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .trace_enabled_i   (en),
        .trace_start_i     (start),
        .force_sync_i      (force_s),
        .gt_resync_max_i   (gt),
        .et_resync_max_i   (et),
        .sync_ready_i      (ready),
        .sync_valid_o      (valid),
        .sync_cause_o      (cause),
        .resync_rst_o      (rst_pulse),
        .resync_imminent_o (imminent),
        .merged_cnt_o      (merged)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_err = 0;

    // Reference model: mode 0=tracing off, 1=waiting, 2=requesting, 3=clearing
    int m_mode;
    bit m_pend [3];
    int m_cause;
    int m_valid;
    int m_rst;
    int m_merged;
    int m_gt_prev;

    task automatic chk(input string tag, input int act, input int exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic model_step();
        int rise;
        bit others;
        if (!rst_n) begin
            m_mode = 0; m_cause = 3; m_valid = 0; m_rst = 0; m_merged = 0; m_gt_prev = 0;
            for (int i = 0; i < 3; i++) m_pend[i] = 0;
            return;
        end
        rise = (gt && !m_gt_prev) ? 1 : 0;
        m_gt_prev = gt ? 1 : 0;
        m_rst = 0;
        if (m_mode == 0) begin
            if (start) m_pend[0] = 1;
            if (en) m_mode = 1;
        end else if (!en) begin
            m_mode = 0; m_cause = 3; m_rst = 1;
            for (int i = 0; i < 3; i++) m_pend[i] = 0;
        end else begin
            if (start) m_pend[0] = 1;
            if (force_s) m_pend[1] = 1;
            if (rise == 1) m_pend[2] = 1;
            if (m_mode == 2) begin
                if (m_valid == 1 && ready) begin
                    others = 0;
                    for (int i = 0; i < 3; i++) if (i != m_cause && m_pend[i]) others = 1;
                    if (others && m_merged < CNTMAX) m_merged++;
                    for (int i = 0; i < 3; i++) m_pend[i] = 0;
                    m_mode = 3; m_cause = 3; m_rst = 1;
                end
            end else begin
                m_mode = 1;
                for (int i = 2; i >= 0; i--) begin
                    if (m_pend[i]) begin
                        m_mode = 2;
                        m_cause = i;
                    end
                end
            end
        end
        m_valid = (m_mode == 2) ? 1 : 0;
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("valid", 32'(valid), m_valid);
        chk("cause", 32'(cause), m_cause);
        chk("resync_rst", 32'(rst_pulse), m_rst);
        chk("imminent", 32'(imminent), (et && en && m_mode == 1) ? 1 : 0);
        chk("merged", 32'(merged), m_merged);
    endtask

    int vcnt;
    int rcnt;

    initial begin
        rst_n = 0; en = 0; start = 0; force_s = 0; gt = 0; et = 0; ready = 0;
        tick(); tick();
        chk("reset_valid", 32'(valid), 0);
        chk("reset_cause", 32'(cause), 3);
        chk("reset_merged", 32'(merged), 0);
        rst_n = 1;

        // Enable, start pulse, ready high: one-cycle request with START cause
        en = 1; et = 1; tick();
        chk("imminent_idle", 32'(imminent), 1);
        et = 0; start = 1; ready = 1; tick();
        start = 0;
        chk("start_valid", 32'(valid), 1);
        chk("start_cause", 32'(cause), 0);
        tick();
        chk("start_dropped", 32'(valid), 0);
        chk("start_rst", 32'(rst_pulse), 1);
        tick();
        chk("start_rst_once", 32'(rst_pulse), 0);

        // Threshold rise with ready stalled five cycles
        ready = 0; gt = 1; vcnt = 0; rcnt = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (valid) vcnt++;
            if (rst_pulse) rcnt++;
            if (valid && cause != 2'd2) chk("timeout_cause", 32'(cause), 2);
            ready = (k >= 5);
        end
        chk("timeout_valid_cycles", vcnt, 6);
        chk("timeout_single_rst", rcnt, 1);
        gt = 0; tick();

        // Force arriving during a timeout request is absorbed
        ready = 0; gt = 1; tick();
        force_s = 1; tick();
        force_s = 0;
        chk("merge_cause_kept", 32'(cause), 2);
        ready = 1; tick();
        chk("merge_count", 32'(merged), 1);
        tick(); tick();
        chk("merge_no_second", 32'(valid), 0);
        gt = 0;

        // Force during CLEAR starts a second request right after it
        force_s = 1; tick();
        force_s = 0; tick();
        chk("clear_rst", 32'(rst_pulse), 1);
        force_s = 1; tick();
        force_s = 0;
        chk("clear_second_valid", 32'(valid), 1);
        chk("clear_second_cause", 32'(cause), 1);
        tick(); tick();

        // Enable drops while requesting
        ready = 0; start = 1; tick();
        start = 0; en = 0; tick();
        chk("abort_valid", 32'(valid), 0);
        chk("abort_rst", 32'(rst_pulse), 1);
        tick();
        en = 1; tick();

        // Five merges saturate the narrow counter
        for (int k = 0; k < 5; k++) begin
            ready = 0; start = 1; force_s = 1; tick();
            start = 0; force_s = 0; ready = 1; tick();
            ready = 0; tick();
        end
        chk("merge_saturated", 32'(merged), CNTMAX);

        // Reset while a request is pending
        start = 1; tick();
        start = 0; rst_n = 0; tick();
        chk("reset_mid_valid", 32'(valid), 0);
        chk("reset_mid_rst", 32'(rst_pulse), 0);
        rst_n = 1; tick();

        // Randomized traffic against the model
        for (int k = 0; k < 4000; k++) begin
            rst_n   = ($urandom_range(0, 599) != 0);
            if ($urandom_range(0, 39) == 0) en = ~en;
            start   = ($urandom_range(0, 9) == 0);
            force_s = ($urandom_range(0, 9) == 0);
            if ($urandom_range(0, 5) == 0) gt = ~gt;
            et      = $urandom_range(0, 1);
            ready   = ($urandom_range(0, 2) != 0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/trdb_resync_ctrl.md
TRDB_RESYNC_CTRL -- requirements
Module: trdb_resync_ctrl

Interface
REQ-001 SHALL have parameter MERGE_CNT_W, default 8, width of the saturating merged-request counter.
REQ-002 SHALL have ports: clk_i  input  1  clock, all logic on rising edge.
REQ-003 SHALL have: rst_ni  input  1  reset, synchronous, active-low.
REQ-004 SHALL have: trace_enabled_i  input  1  filter qualification, high while tracing.
REQ-005 SHALL have: trace_start_i  input  1  one-cycle pulse, first qualified instruction after enable.
REQ-006 SHALL have: force_sync_i  input  1  one-cycle user/debug sync request.
REQ-007 SHALL have: gt_resync_max_i  input  1  resync counter threshold-reached level.
REQ-008 SHALL have: et_resync_max_i  input  1  resync counter one-below-threshold level.
REQ-009 SHALL have: sync_ready_i  input  1  packet emitter accepts sync request.
REQ-010 SHALL have: sync_valid_o  output  1  sync packet request.
REQ-011 SHALL have: sync_cause_o  output  2  sync_cause_e of current request.
REQ-012 SHALL have: resync_rst_o  output  1  one-cycle clear pulse to resync counter.
REQ-013 SHALL have: resync_imminent_o  output  1  et_resync_max_i && trace_enabled_i && state==IDLE, combinational.
REQ-014 SHALL have: merged_cnt_o  output  MERGE_CNT_W  saturating count of requests absorbed by another sync.

Function
REQ-015 SHALL implement FSM states OFF, IDLE, REQ, CLEAR.
REQ-016 OFF: leave to IDLE when trace_enabled_i=1; all event inputs ignored except trace_start_i, which sets its pending flag.
REQ-017 SHALL hold three pending flags (start, force, timeout); flags set by trace_start_i, force_sync_i, rising edge of gt_resync_max_i (registered previous value).
REQ-018 IDLE: when any flag set (including one set that cycle), go REQ next cycle.
REQ-019 REQ: sync_valid_o=1; sync_cause_o = highest-priority pending flag, priority START > FORCE > TIMEOUT; cause latched on REQ entry and stable until transfer.
REQ-020 Transfer SHALL occur when sync_valid_o && sync_ready_i; then go CLEAR; sync_valid_o SHALL NOT drop before transfer.
REQ-021 On transfer all pending flags SHALL clear; if any flag other than the served one was set, merged_cnt_o SHALL increment by 1, saturating at all-ones.
REQ-022 CLEAR: resync_rst_o=1 for exactly one cycle; then IDLE, or REQ if a flag was set during CLEAR.
REQ-023 Events arriving in the transfer cycle SHALL be merged; events in CLEAR SHALL be kept.
REQ-024 trace_enabled_i falling in IDLE/REQ/CLEAR: next state OFF, flags cleared, sync_valid_o dropped (abort), resync_rst_o=1 that cycle; merged_cnt_o unchanged.
REQ-025 gt_resync_max_i held high SHALL produce one request only; new request needs low then high.
REQ-026 Latency: event in IDLE -> sync_valid_o high next cycle; transfer -> resync_rst_o next cycle.

Reset
REQ-027 On rst_ni=0 at clock edge: state OFF, flags 0, gt edge register 0, sync_valid_o 0, sync_cause_o SYNC_NONE, resync_rst_o 0, merged_cnt_o 0.
REQ-028 Reset mid-REQ SHALL drop sync_valid_o at the reset edge without a resync_rst_o pulse.

Structure
REQ-029 sync_cause_e (SYNC_START=0, SYNC_FORCE=1, SYNC_TIMEOUT=2, SYNC_NONE=3) and FSM state enum SHALL live in trdb_pkg.
REQ-030 SHALL be a single module, no sub-modules; drives trdb_resync_counter resync_rst_i.

Verification
REQ-031 Enable, trace_start_i pulse, sync_ready_i=1 -> sync_valid_o 1 cycle, cause 0, resync_rst_o next cycle.
REQ-032 gt_resync_max_i rises, sync_ready_i low 5 cycles -> sync_valid_o held 5+1 cycles, cause 2 stable, single resync_rst_o.
REQ-033 In REQ(cause 2), force_sync_i pulse -> cause stays 2, merged_cnt_o 0->1 on transfer, no second request.
REQ-034 force_sync_i during CLEAR -> second request cause 1 immediately after CLEAR.
REQ-035 trace_enabled_i drops in REQ -> sync_valid_o 0 next cycle, resync_rst_o 1 that cycle, state OFF.
REQ-036 MERGE_CNT_W=2, 5 merges -> merged_cnt_o saturates at 3.
